// File: rtl/stopwatch_ctrl_if.sv
// Control/data bundle between the stopwatch controller and its
// surroundings: pulses in, chain value in, step/clear/display out.
interface stopwatch_ctrl_if;
  logic        start_stop;
  logic        lap_reset;
  logic [15:0] count_value;
  logic        top_over;
  logic        increase;
  logic        clear;
  logic [15:0] disp_value;
  logic [2:0]  state;
  logic        running;

  modport master (
    output start_stop, lap_reset,
    output count_value, top_over,
    input  increase, clear,
    input  disp_value, state, running
  );

  modport slave (
    input  start_stop, lap_reset,
    input  count_value, top_over,
    output increase, clear,
    output disp_value, state, running
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/reset controller for a BCD stopwatch digit chain.
// Define STOPWATCH_WRAP_EN to wrap at full scale instead of stopping.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100,
  parameter int PRESC_W  = 16
) (
  input  logic clk_out,
  input  logic rst,
  stopwatch_ctrl_if.slave sw
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    DONE  = 3'd4
  } st_t;

  localparam logic [PRESC_W-1:0] LP_LAST =
    PRESC_W'(TICK_DIV - 1);

  st_t                r_state;
  st_t                w_next;
  logic [PRESC_W-1:0] r_presc;
  logic [15:0]        r_disp;
  logic               r_clear;
  logic               r_running;
  logic               w_active;
  logic               w_inc;
  logic               w_full;
  logic               w_clr;
  logic               w_hold;

  assign w_active = (r_state == RUN) ||
                    (r_state == LAP);
  assign w_inc    = w_active &&
                    (r_presc == LP_LAST);

`ifdef STOPWATCH_WRAP_EN
  assign w_full = 1'b0;
`else
  assign w_full = w_inc && sw.top_over;
`endif

  always_comb begin
    w_next = IDLE;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        if (sw.start_stop) begin
          w_next = RUN;
        end else begin
          w_next = IDLE;
          w_clr  = sw.lap_reset;
        end
      end
      RUN: begin
        if (w_full)              w_next = DONE;
        else if (sw.start_stop)  w_next = PAUSE;
        else if (sw.lap_reset)   w_next = LAP;
        else                     w_next = RUN;
      end
      LAP: begin
        if (w_full)              w_next = DONE;
        else if (sw.start_stop)  w_next = PAUSE;
        else if (sw.lap_reset)   w_next = RUN;
        else                     w_next = LAP;
      end
      PAUSE: begin
        if (sw.start_stop) begin
          w_next = RUN;
        end else if (sw.lap_reset) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else begin
          w_next = PAUSE;
        end
      end
`ifndef STOPWATCH_WRAP_EN
      DONE: begin
        if (sw.lap_reset) begin
          w_next = IDLE;
          w_clr  = 1'b1;
        end else begin
          w_next = DONE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  // display is frozen only while staying in LAP or DONE
  assign w_hold =
    ((r_state == LAP)  && (w_next == LAP)) ||
    ((r_state == DONE) && (w_next == DONE));

  always_ff @(posedge clk_out) begin
    if (rst) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_disp    <= '0;
      r_clear   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_clear   <= w_clr;
      r_running <= (w_next == RUN) ||
                   (w_next == LAP);
      if (w_active) begin
        r_presc <= w_inc ? '0 : r_presc + 1'b1;
      end else if ((r_state == PAUSE) &&
                   (w_next != IDLE)) begin
        r_presc <= r_presc;
      end else begin
        r_presc <= '0;
      end
      if (!w_hold) begin
        r_disp <= sw.count_value;
      end
    end
  end

  assign sw.increase   = w_inc;
  assign sw.clear      = r_clear;
  assign sw.disp_value = r_disp;
  assign sw.state      = r_state;
  assign sw.running    = r_running;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed plan plus random pulses,
// checked every cycle against a behavioural stopwatch model.
module tb_stopwatch_ctrl;

  localparam int D = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;
  localparam int M_DONE  = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(
    .TICK_DIV(D),
    .PRESC_W (16)
  ) dut (
    .clk_out(clk),
    .rst    (rst),
    .sw     (sw)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int          m_mode = M_IDLE;
  int          m_el   = 0;
  logic [15:0] m_disp = '0;
  bit          m_clr  = 1'b0;
  bit          m_run  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic bit counting(input int m);
    return (m == M_RUN) || (m == M_LAP);
  endfunction

  // one count step every D cycles spent counting;
  // elapsed time survives a pause but not a clear
  function automatic bit m_step_now();
    return counting(m_mode) && ((m_el % D) == D - 1);
  endfunction

  task automatic model(input bit r, input bit ss,
                       input bit lr, input logic [15:0] cv,
                       input bit to);
    bit full;
    int nm;
    bit clr;
    full = 1'b0;
    clr  = 1'b0;
`ifndef STOPWATCH_WRAP_EN
    full = m_step_now() && to;
`endif
    if (r) begin
      m_mode = M_IDLE; m_el = 0; m_disp = '0;
      m_clr = 0; m_run = 0;
      return;
    end
    nm = m_mode;
    if (counting(m_mode) && full)
      nm = M_DONE;
    else if (m_mode == M_DONE)
      nm = lr ? M_IDLE : M_DONE;
    else if (ss)
      nm = (m_mode == M_IDLE || m_mode == M_PAUSE)
           ? M_RUN : M_PAUSE;
    else if (lr)
      case (m_mode)
        M_IDLE:  nm = M_IDLE;
        M_RUN:   nm = M_LAP;
        M_LAP:   nm = M_RUN;
        default: nm = M_IDLE;
      endcase
    clr = lr && (m_mode == M_DONE ||
          (!ss && (m_mode == M_IDLE ||
                   m_mode == M_PAUSE)));
    if (counting(m_mode))
      m_el = m_el + 1;
    else if (!(m_mode == M_PAUSE && nm != M_IDLE))
      m_el = 0;
    if (!((m_mode == nm) &&
          (nm == M_LAP || nm == M_DONE)))
      m_disp = cv;
    m_mode = nm;
    m_clr  = clr;
    m_run  = counting(nm);
  endtask

  task automatic cyc(input bit r, input bit ss,
                     input bit lr, input logic [15:0] cv,
                     input bit to);
    @(negedge clk);
    rst            = r;
    sw.start_stop  = ss;
    sw.lap_reset   = lr;
    sw.count_value = cv;
    sw.top_over    = to;
    @(posedge clk);
    model(r, ss, lr, cv, to);
    #1;
    chk("state",    {29'd0, sw.state}, m_mode);
    chk("running",  {31'd0, sw.running}, {31'd0, m_run});
    chk("clear",    {31'd0, sw.clear}, {31'd0, m_clr});
    chk("increase", {31'd0, sw.increase},
        {31'd0, m_step_now()});
    chk("disp",     {16'd0, sw.disp_value}, {16'd0, m_disp});
  endtask

  logic [15:0] cv;

  initial begin
    rst = 1'b1;
    sw.start_stop  = 1'b0;
    sw.lap_reset   = 1'b0;
    sw.count_value = '0;
    sw.top_over    = 1'b0;
    cv = 16'h0000;

    cyc(1, 0, 0, cv, 0);
    cyc(1, 0, 0, cv, 0);
    cyc(0, 1, 0, cv, 0);
    for (int i = 0; i < 13; i++) begin
      cv = cv + 16'h1;
      cyc(0, 0, 0, cv, 0);
    end

    for (int i = 0; i < D && (m_el % D) != 1; i++)
      cyc(0, 0, 0, cv, 0);
    cyc(0, 1, 0, cv, 0);
    for (int i = 0; i < 10; i++)
      cyc(0, 0, 0, cv, 0);
    cyc(0, 1, 0, cv, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, cv, 0);

    cyc(0, 0, 1, 16'h0012, 0);
    cyc(0, 0, 0, 16'h0013, 0);
    cyc(0, 0, 0, 16'h0014, 0);
    cyc(0, 0, 0, 16'h0015, 0);
    cyc(0, 0, 1, 16'h0015, 0);
    cyc(0, 0, 0, 16'h0015, 0);

    cyc(0, 1, 0, cv, 0);
    cyc(0, 0, 1, cv, 0);
    cyc(0, 1, 0, cv, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, cv, 0);

    for (int i = 0; i < 6; i++)
      cyc(0, 0, 0, 16'h5959, 1);
    cyc(0, 1, 0, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0001, 0);
    cyc(0, 0, 0, 16'h0002, 0);
    cyc(0, 0, 1, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 0);

    cyc(0, 1, 0, 16'h0100, 0);
    cyc(0, 0, 0, 16'h0101, 0);
    cyc(0, 0, 0, 16'h0102, 0);
    cyc(0, 1, 1, 16'h0103, 0);
    cyc(0, 1, 0, 16'h0104, 0);
    cyc(0, 0, 1, 16'h0105, 0);
    cyc(0, 0, 0, 16'h0106, 0);
    cyc(1, 0, 0, 16'h0107, 0);
    cyc(0, 0, 0, 16'h0108, 0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 7) == 0),
          16'($urandom),
          ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
